// File: rtl/input_conditioner_pkg.sv
// ---------------------------------------------------------------------------
// input_conditioner_pkg
// Shared definitions (ic_defs) for the input conditioner: debounce FSM state
// encodings and the default qualification length.
// ---------------------------------------------------------------------------
package input_conditioner_pkg;

    // Encoding keeps bit 1 equal to the accepted level in the ST_* states.
    typedef enum logic [1:0] {
        ST_LOW   = 2'b00,
        CHK_HIGH = 2'b01,
        ST_HIGH  = 2'b11,
        CHK_LOW  = 2'b10
    } ic_state_t;

    localparam int DEBOUNCE_DEFAULT = 4;

endpackage

// File: rtl/input_conditioner_if.sv
// ---------------------------------------------------------------------------
// input_conditioner_if
// Groups the raw button input and the conditioned outputs.
//   BTN_IN : raw asynchronous input (driven by the master side)
//   X_OUT  : debounced level
//   X_RISE : one-cycle strobe on 0->1 of X_OUT
//   X_FALL : one-cycle strobe on 1->0 of X_OUT
// master = the environment driving the button, slave = the conditioner.
// ---------------------------------------------------------------------------
interface input_conditioner_if;
    logic BTN_IN;
    logic X_OUT;
    logic X_RISE;
    logic X_FALL;

    modport master (
        output BTN_IN,
        input  X_OUT,
        input  X_RISE,
        input  X_FALL
    );

    modport slave (
        input  BTN_IN,
        output X_OUT,
        output X_RISE,
        output X_FALL
    );
endinterface

// File: rtl/sync_2ff.sv
// ---------------------------------------------------------------------------
// sync_2ff
// Two-flop synchronizer for a single asynchronous bit.
//   CLK : system clock
//   RST : synchronous active-high reset, clears both flops
//   d   : asynchronous input
//   q   : synchronized output (second flop)
// ---------------------------------------------------------------------------
module sync_2ff (
    input  logic CLK,
    input  logic RST,
    input  logic d,
    output logic q
);

    logic sync1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            sync1 <= 1'b0;
            q     <= 1'b0;
        end else begin
            sync1 <= d;
            q     <= sync1;
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// ---------------------------------------------------------------------------
// input_conditioner
// Turns a raw, bouncing one-bit input into a clean clock-synchronous level
// plus one-cycle rise/fall strobes. A 2-flop synchronizer feeds a 4-state
// debounce FSM; a new level is accepted only after DEBOUNCE_CYCLES
// consecutive synchronized samples agree.
//   CLK : system clock
//   RST : synchronous active-high reset
//   io  : slave side of input_conditioner_if (BTN_IN in; X_OUT/X_RISE/X_FALL out)
// Parameters:
//   DEBOUNCE_CYCLES : samples needed to accept a level (2..255)
//   CNT_W           : counter width, 2**CNT_W > DEBOUNCE_CYCLES
// ---------------------------------------------------------------------------
module input_conditioner
    import input_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
    parameter int CNT_W           = 8
) (
    input  logic                 CLK,
    input  logic                 RST,
    input_conditioner_if.slave   io
);

    logic             sync2;
    ic_state_t        state;
    ic_state_t        state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             x_out_q;
    logic             x_out_nxt;
    logic             x_rise_q;
    logic             x_rise_nxt;
    logic             x_fall_q;
    logic             x_fall_nxt;
    logic             at_limit;

    sync_2ff u_sync (
        .CLK (CLK),
        .RST (RST),
        .d   (io.BTN_IN),
        .q   (sync2)
    );

    // The count already holds N-1 agreeing samples; the current one is the Nth.
    assign at_limit = (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

    // State, counter and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= ST_LOW;
            cnt      <= '0;
            x_out_q  <= 1'b0;
            x_rise_q <= 1'b0;
            x_fall_q <= 1'b0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            x_out_q  <= x_out_nxt;
            x_rise_q <= x_rise_nxt;
            x_fall_q <= x_fall_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOW:   if (sync2)         state_nxt = CHK_HIGH;
            CHK_HIGH: if (!sync2)        state_nxt = ST_LOW;
                      else if (at_limit) state_nxt = ST_HIGH;
            ST_HIGH:  if (!sync2)        state_nxt = CHK_LOW;
            CHK_LOW:  if (sync2)         state_nxt = ST_HIGH;
                      else if (at_limit) state_nxt = ST_LOW;
            default:                     state_nxt = ST_LOW;
        endcase
    end

    // Output and counter logic; strobes default low every cycle and the
    // counter is cleared on every qualification or abort.
    always_comb begin
        cnt_nxt    = cnt;
        x_out_nxt  = x_out_q;
        x_rise_nxt = 1'b0;
        x_fall_nxt = 1'b0;
        case (state)
            ST_LOW:   cnt_nxt = sync2 ? CNT_W'(1) : '0;
            CHK_HIGH: begin
                if (!sync2) begin
                    cnt_nxt = '0;
                end else if (at_limit) begin
                    cnt_nxt    = '0;
                    x_out_nxt  = 1'b1;
                    x_rise_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            ST_HIGH:  cnt_nxt = sync2 ? '0 : CNT_W'(1);
            CHK_LOW:  begin
                if (sync2) begin
                    cnt_nxt = '0;
                end else if (at_limit) begin
                    cnt_nxt    = '0;
                    x_out_nxt  = 1'b0;
                    x_fall_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default:  cnt_nxt = '0;
        endcase
    end

    assign io.X_OUT  = x_out_q;
    assign io.X_RISE = x_rise_q;
    assign io.X_FALL = x_fall_q;

endmodule

// File: doc/input_conditioner.md
# input_conditioner

Upstream input stage for the sequence-detecting FSM: takes a raw, asynchronous, possibly bouncing one-bit input (switch or pushbutton) and produces a clean, clock-synchronous level that drives the FSM's serial X input. It also produces one-cycle rise and fall strobes for counters and LEDs. Internally it uses a 2-flop synchronizer followed by a 4-state debounce FSM with a qualification counter.

## Interface
- DEBOUNCE_CYCLES, default 4: number of consecutive synchronized samples required to accept a new level. Legal range is 2..255.
- CNT_W, default 8: width of the qualification counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- CLK  input  1  single system clock; all state updates on the rising edge.
- RST  input  1  reset; synchronous and active-high.
- BTN_IN  input  1  raw asynchronous input; may glitch or bounce.
- X_OUT  output  1  debounced level; connects to the FSM X input.
- X_RISE  output  1  one-cycle strobe, asserted on the cycle X_OUT goes 0→1.
- X_FALL  output  1  one-cycle strobe, asserted on the cycle X_OUT goes 1→0.

## Operation
- Synchronizer: sync1 <= BTN_IN, then sync2 <= sync1. Only sync2 is used downstream.
- States are ST_LOW, CHK_HIGH, ST_HIGH and CHK_LOW.
- ST_LOW:
  - sync2=1 → CHK_HIGH, cnt<=1.
  - Otherwise stay.
- CHK_HIGH:
  - sync2=0 → ST_LOW, cnt<=0. This is a rejected glitch; no strobe is produced.
  - sync2=1 and cnt==DEBOUNCE_CYCLES-1 → ST_HIGH, X_OUT<=1, X_RISE<=1.
  - sync2=1 otherwise → cnt<=cnt+1.
- ST_HIGH and CHK_LOW mirror ST_LOW and CHK_HIGH with polarities swapped. Qualification ends in X_OUT<=0 and X_FALL<=1.
- X_OUT is registered and changes only on qualification. It holds its value in CHK_* states.
- X_RISE and X_FALL are registered and default to 0 every cycle. They are never asserted together.
- Counter: unsigned, and it never wraps. It is cleared on every entry to ST_* and on every abort.
- Reset (RST=1 at an edge):
  - sync1, sync2, cnt, X_OUT, X_RISE and X_FALL all become 0; state becomes ST_LOW.
  - Reset wins over any transition in the same cycle.
  - Reset mid-qualification discards the partial count.
  - If BTN_IN is high when reset is released, it must re-qualify with the full latency before X_RISE is produced.

## Timing
- Reset value of every output is 0.
- Latency, with N = DEBOUNCE_CYCLES:
  - BTN_IN becomes stable-high before edge k, so sync1=1 at edge k.
  - X_OUT=1 and X_RISE=1 become visible after edge k+N+1.
  - X_RISE drops after edge k+N+2.
  - Falling latency is identical.
- Minimum accepted pulse: sync2 must be held for N consecutive edges. A BTN_IN pulse of N-1 cycles or fewer never changes X_OUT.
- Bounce restarts qualification from the start. Each abort returns to ST_* and needs a fresh run of N samples.
- Back-to-back changes: after X_OUT rises, a fall can qualify at the earliest N edges later, so strobes are separated by at least N cycles.

## Structure
- Shared package/header ic_defs holds:
  - state encodings ST_LOW=2'b00, CHK_HIGH=2'b01, ST_HIGH=2'b11, CHK_LOW=2'b10;
  - DEBOUNCE_DEFAULT=4.
- One sub-module, sync_2ff (1-bit, CLK/RST, synchronous reset to 0), which other input stages reuse.
- The top level instantiates sync_2ff and contains the debounce FSM, the counter and the output registers.

## Test plan
All scenarios use CLK period 10 ns, N=4, and RST held high for the first 2 edges.
- Clean press: BTN_IN 0→1 just before edge k and held → X_OUT=1 and X_RISE pulses for exactly one cycle after edge k+5; X_FALL stays 0.
- Glitch rejection: BTN_IN high for 3 cycles, then low → X_OUT, X_RISE and X_FALL stay 0 throughout.
- Bounce: BTN_IN pattern 1,0,1,1,0,1,1,1,1 (one value per cycle), then held high → exactly one X_RISE, occurring after the final 4-sample run; X_OUT=1.
- Release: from X_OUT=1, BTN_IN→0 held → X_FALL one-cycle pulse and X_OUT=0, 5 edges after sync1 samples 0.
- Reset mid-qualification: BTN_IN high, RST asserted 2 edges into CHK_HIGH, then released with BTN_IN still high → X_OUT stays 0 during reset; X_RISE occurs only after a full re-qualification from the release edge.
- FSM integration: drive the FSM's existing X stimulus (0, then 1 for 100 ns, 0 for 50 ns, then a 10 ns pulse) through this block → X_OUT tracks the two long intervals delayed by 6 cycles; the 10 ns pulse is filtered.
